frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_pkg.sv | 14 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/frame_reader.sv | 140 ++++++++++++++
 tb/tb_frame_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared image geometry defaults and the frame reader state encoding.
package frame_pkg;
  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = 19;
  localparam int IMG_W   = 640;
  localparam int IMG_H   = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is presented combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = {PW{1'b0}};
    else                     next_ptr = p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == {CW{1'b0}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and count; a simultaneous push and pop keeps count steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {WIDTH{1'b0}};
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/frame_reader.sv
// Streams one frame from a 1-cycle-latency memory into a ready/valid pixel port,
// throttling reads so the output FIFO can never overflow.
module frame_reader #(
  parameter int D_WIDTH    = frame_pkg::D_WIDTH,
  parameter int A_WIDTH    = frame_pkg::A_WIDTH,
  parameter int IMG_W      = frame_pkg::IMG_W,
  parameter int IMG_H      = frame_pkg::IMG_H,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               mem_ren,
  output logic [A_WIDTH-1:0] mem_raddr,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic [D_WIDTH-1:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               busy,
  output logic               done
);
  import frame_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NW   = $clog2(NPIX);
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [A_WIDTH-1:0] BASE = A_WIDTH'(BASE_ADDR);

  state_t         state;
  logic           inflight;
  logic [NW-1:0]  rd_idx;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           last_rd;
  logic           drained;

  // The read issued last cycle lands on mem_rdata now and is pushed on this edge.
  sync_fifo #(
    .WIDTH (D_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (pop),
    .pop_data  (pix_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign pix_eol   = pix_valid && (col == CW'(IMG_W - 1));
  assign pix_eof   = pix_eol && (row == RW'(IMG_H - 1));
  assign last_rd   = (rd_idx == NW'(NPIX - 1));
  // Leave DRAIN as soon as the final pixel is leaving, so done follows the eof transfer directly.
  assign drained   = !inflight && (fifo_empty || ((fifo_count == FCW'(1)) && pop));

  // Read request: occupancy plus the read still in flight must leave room in the FIFO.
  always_comb begin
    mem_ren = 1'b0;
    if ((state == FETCH) && !fifo_full) begin
      mem_ren = ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));
    end else begin
      mem_ren = 1'b0;
    end
  end

  // Sequencer: frame state, read address, output-side position and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      rd_idx    <= {NW{1'b0}};
      mem_raddr <= BASE;
      col       <= {CW{1'b0}};
      row       <= {RW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= mem_ren;
      if (pop) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= {CW{1'b0}};
          row <= (row == RW'(IMG_H - 1)) ? {RW{1'b0}} : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ren) begin
            if (last_rd) begin
              state     <= DRAIN;
              rd_idx    <= {NW{1'b0}};
              mem_raddr <= BASE;
            end else begin
              rd_idx    <= rd_idx + NW'(1);
              mem_raddr <= mem_raddr + A_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a 4x2 frame at base 0x100 with a byte-echo memory.
module tb_frame_reader;
  localparam int DW    = 8;
  localparam int AW    = 19;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int NPIX  = W * H;
  localparam int DEPTH = 4;
  localparam int BASE  = 32'h100;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          start     = 1'b0;
  logic          pix_ready = 1'b0;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = 8'h00;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  frame_reader #(
    .D_WIDTH    (DW),
    .A_WIDTH    (AW),
    .IMG_W      (W),
    .IMG_H      (H),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .busy      (busy),
    .done      (done)
  );

  // memory model: data[a] = a[7:0], one cycle latency
  always @(posedge clk) if (mem_ren) mem_rdata <= mem_raddr[7:0];

  int            cyc = 0;
  int            ren_cyc[$];
  int            xfer_cyc[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] pix_q[$];
  logic          eol_q[$];
  logic          eof_q[$];
  int            start_cyc, eof_cyc, done_cyc, done_cnt, busy_at_done, max_out;

  always @(posedge clk) begin
    if (rst_n) begin
      if (start && start_cyc < 0) start_cyc = cyc;
      if (mem_ren) begin
        ren_cyc.push_back(cyc);
        addr_q.push_back(mem_raddr);
      end
      if (pix_valid && pix_ready) begin
        xfer_cyc.push_back(cyc);
        pix_q.push_back(pix_data);
        eol_q.push_back(pix_eol);
        eof_q.push_back(pix_eof);
        if (pix_eof) eof_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = int'(busy);
      end
      if (ren_cyc.size() - xfer_cyc.size() > max_out) max_out = ren_cyc.size() - xfer_cyc.size();
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ren_cyc.delete(); xfer_cyc.delete(); addr_q.delete();
    pix_q.delete(); eol_q.delete(); eof_q.delete();
    start_cyc = -1; eof_cyc = -1; done_cyc = -1; done_cnt = 0;
    busy_at_done = -1; max_out = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check({tag, " done_seen"}, done_cnt, 1);
  endtask

  // Whole-frame content: addresses BASE.., pixels = address low byte, eol every W, eof on last.
  task automatic check_frame(input string tag);
    check({tag, " n_reads"}, ren_cyc.size(), NPIX);
    check({tag, " n_xfers"}, pix_q.size(), NPIX);
    for (int i = 0; i < NPIX && i < addr_q.size(); i++)
      check($sformatf("%s addr[%0d]", tag, i), addr_q[i], BASE + i);
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) begin
      check($sformatf("%s pix[%0d]", tag, i), pix_q[i], (BASE + i) & 8'hFF);
      check($sformatf("%s eol[%0d]", tag, i), eol_q[i], (i % W) == W - 1);
      check($sformatf("%s eof[%0d]", tag, i), eof_q[i], i == NPIX - 1);
    end
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " max_outstanding_ok"}, max_out <= DEPTH, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " mem_ren"}, mem_ren, 0);
    check({tag, " mem_raddr"}, mem_raddr, BASE);
    check({tag, " pix_valid"}, pix_valid, 0);
    check({tag, " pix_data"}, pix_data, 0);
    check({tag, " pix_eol"}, pix_eol, 0);
    check({tag, " pix_eof"}, pix_eof, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  initial begin
    int bad;
    clear_mon();
    #2 rst_n = 1'b0;
    tick(2);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(6);
    check("post_reset no_reads", ren_cyc.size(), 0);

    // A: ready held high, latency and back-to-back stream
    clear_mon();
    pix_ready = 1'b1;
    pulse_start();
    wait_done("A", 60);
    tick(3);
    check_frame("A");
    if (ren_cyc.size() > 0) check("A first_ren_cycle", ren_cyc[0], start_cyc + 1);
    if (xfer_cyc.size() == NPIX) begin
      check("A first_valid_cycle", xfer_cyc[0], start_cyc + 3);
      check("A back_to_back", xfer_cyc[NPIX-1] - xfer_cyc[0], NPIX - 1);
    end
    check("A done_after_eof", done_cyc, eof_cyc + 1);
    check("A busy_at_done", busy_at_done, 0);
    check("A busy_idle", busy, 0);

    // B: ready at roughly 30% duty
    clear_mon();
    pix_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      pix_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
    end
    pix_ready = 1'b1;
    check("B done_seen", done_cnt, 1);
    tick(3);
    check_frame("B");

    // C: sink stalled for 20 cycles after start
    clear_mon();
    pix_ready = 1'b0;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (pix_valid && (pix_data !== 8'h00 || pix_eol !== 1'b0)) bad++;
    end
    check("C reads_while_stalled", ren_cyc.size(), DEPTH);
    check("C head_changed", bad, 0);
    check("C pix_valid", pix_valid, 1);
    check("C pix_data", pix_data, 8'h00);
    pix_ready = 1'b1;
    wait_done("C", 60);
    tick(3);
    check_frame("C");
    if (pix_q.size() > 4) check("C resume_pixel", pix_q[4], 8'h04);

    // D: start re-pulsed during FETCH and during DONE
    clear_mon();
    pulse_start();
    tick(2);
    pulse_start();
    for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
    check("D done_visible", done, 1);
    pulse_start();
    tick(8);
    check_frame("D");
    check("D busy_idle", busy, 0);

    // E: reset in the middle of a frame, then replay
    clear_mon();
    pulse_start();
    for (int i = 0; i < 40 && pix_q.size() < 3; i++) @(negedge clk);
    check("E reached_pixel3", pix_q.size() >= 3, 1);
    check("E busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("E reset");
    tick(2);
    rst_n = 1'b1;
    clear_mon();
    tick(8);
    check("E no_reads_after_reset", ren_cyc.size(), 0);
    pulse_start();
    wait_done("E", 60);
    tick(3);
    check_frame("E");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
